multiboot_request: RTL

Reboot-request front end for the Spartan-6 multiboot path. Watches an active-low hold-to-exit button combo and a single-cycle request strobe from the menu logic. It latches the target bitstream's SPI address from a slot index and emits one clean REBOOT pulse whose falling edge triggers the ICAP reboot sequencer downstream. The block is single-shot: once it fires it stays locked until reset, because the FPGA reconfigures anyway.

---
 rtl/multiboot_request.sv | 103 ++++++++++
 1 files changed

// File: rtl/multiboot_request.sv
// Reboot-request front end for the multiboot path: a held button combo or a menu
// request produces one REBOOT pulse with a latched SPI address, then the block locks.
module multiboot_request #(
    parameter int unsigned NKEYS        = 4,
    parameter logic [23:0] HOLD_CYCLES  = 24'd10_000_000,
    parameter int unsigned PULSE_CYCLES = 8,
    parameter logic [23:0] BASE_ADDR    = 24'h058000,
    parameter logic [23:0] SLOT_STRIDE  = 24'h058000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [NKEYS-1:0] COMBO_N,
    input  logic             REQ,
    input  logic [2:0]       SLOT,
    output logic             REBOOT,
    output logic [23:0]      SPI_ADDR,
    output logic             BUSY,
    output logic             LOCKED
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PULSE, S_LOCK} state_t;

    localparam int unsigned    PCW        = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);

    state_t           r_state;
    logic [NKEYS-1:0] r_sync1;
    logic [NKEYS-1:0] r_sync2;
    logic [23:0]      r_hold_cnt;
    logic [PCW-1:0]   r_pulse_cnt;

    logic             w_pressed;
    logic             w_hold_done;
    logic             w_go;
    logic [23:0]      w_addr;

    assign w_pressed   = (r_sync2 == '0);
    assign w_hold_done = w_pressed && (r_hold_cnt == HOLD_CYCLES - 24'd1);
    // REQ outranks the combo in both IDLE and HOLD.
    assign w_go        = ((r_state == S_IDLE) && REQ) ||
                         ((r_state == S_HOLD) && (REQ || w_hold_done));
    // 24-bit context makes the slot offset wrap modulo 2^24.
    assign w_addr      = BASE_ADDR + 24'(SLOT) * SLOT_STRIDE;

    // NOTE: every register here uses <= so all of them update from pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_pulse_cnt <= '0;
            REBOOT      <= 1'b0;
            BUSY        <= 1'b0;
            LOCKED      <= 1'b0;
            SPI_ADDR    <= BASE_ADDR;
        end else begin
            r_sync1 <= COMBO_N;
            r_sync2 <= r_sync1;
            if (w_go) begin
                r_state     <= S_PULSE;
                r_hold_cnt  <= '0;
                r_pulse_cnt <= '0;
                SPI_ADDR    <= w_addr;
                REBOOT      <= 1'b1;
                BUSY        <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_pressed) begin
                            r_state    <= S_HOLD;
                            r_hold_cnt <= 24'd1;
                            BUSY       <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (!w_pressed) begin
                            r_state    <= S_IDLE;
                            r_hold_cnt <= '0;
                            BUSY       <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 24'd1;
                        end
                    end
                    S_PULSE: begin
                        if (r_pulse_cnt == PULSE_LAST) begin
                            r_state <= S_LOCK;
                            REBOOT  <= 1'b0;
                            BUSY    <= 1'b0;
                            LOCKED  <= 1'b1;
                        end else begin
                            r_pulse_cnt <= r_pulse_cnt + PCW'(1);
                        end
                    end
                    // Terminal until reset; the FPGA reconfigures from here.
                    S_LOCK: ;
                    default: ;
                endcase
            end
        end
    end

endmodule
